// File: rtl/avalon_pio_bank_pkg.sv
// Shared constants for the Avalon-MM PIO bank: register function codes, edge types
// and the channel-address width helper.
package avalon_pio_bank_pkg;
   localparam logic [2:0] FUNC_OUT_DATA = 3'd0;
   localparam logic [2:0] FUNC_OUT_SET  = 3'd1;
   localparam logic [2:0] FUNC_OUT_CLR  = 3'd2;
   localparam logic [2:0] FUNC_IN_DATA  = 3'd3;
   localparam logic [2:0] FUNC_EDGE_CAP = 3'd4;
   localparam logic [2:0] FUNC_IRQ_MASK = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // A single-channel bank still gets one address bit so the port never collapses to zero width.
   function automatic int ch_addr_width(input int num_out, input int num_in);
      int m;
      m = (num_out > num_in) ? num_out : num_in;
      return (m < 2) ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/avalon_pio_bank_in_channel.sv
// One input channel: synchroniser, optional debounce (AVALON_PIO_BANK_DEBOUNCE_EN),
// warm-up gate, edge detect, sticky edge capture and interrupt mask.
module pio_in_channel
   import avalon_pio_bank_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int EDGE_TYPE       = 0,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pio_in,
   input  logic             clr_wr,
   input  logic [WIDTH-1:0] clr_data,
   input  logic             mask_wr,
   input  logic [WIDTH-1:0] mask_data,
   output logic [WIDTH-1:0] filtered,
   output logic [WIDTH-1:0] edge_cap,
   output logic [WIDTH-1:0] irq_mask,
   output logic             irq_req
);
`ifdef AVALON_PIO_BANK_DEBOUNCE_EN
   localparam int WARM = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
   localparam int WARM = SYNC_STAGES + 1;
`endif
   localparam int WW = $clog2(WARM + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
   logic [WIDTH-1:0] synced, prev, edge_raw, edge_hit;
   logic [WW-1:0]    warm_cnt;
   logic             warm_done;

   assign synced    = sync[SYNC_STAGES-1];
   assign warm_done = (warm_cnt == WW'(WARM));

   always_ff @(posedge clk) begin
      if (reset) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], pio_in};
   end

`ifdef AVALON_PIO_BANK_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [WIDTH-1:0][CW-1:0] cnt;

   // Counter restarts on any agreement and clears on the flip, so it never exceeds DEBOUNCE_CYCLES-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         filtered <= '0;
      end else begin
         for (int b = 0; b < WIDTH; b++) begin
            if (synced[b] == filtered[b]) begin
               cnt[b] <= '0;
            end else if (cnt[b] >= CW'(DEBOUNCE_CYCLES - 1)) begin
               filtered[b] <= synced[b];
               cnt[b]      <= '0;
            end else begin
               cnt[b] <= cnt[b] + 1'b1;
            end
         end
      end
   end
`else
   assign filtered = synced;
`endif

   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: edge_raw = ~filtered & prev;
         EDGE_ANY:     edge_raw = filtered ^ prev;
         default:      edge_raw = filtered & ~prev;
      endcase
      edge_hit = warm_done ? edge_raw : '0;
   end

   // New edges are OR-ed in after the W1C, so a same-cycle edge survives its clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev     <= '0;
         warm_cnt <= '0;
         edge_cap <= '0;
         irq_mask <= '0;
      end else begin
         prev <= filtered;
         if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
         edge_cap <= (edge_cap & ~(clr_wr ? clr_data : '0)) | edge_hit;
         if (mask_wr) irq_mask <= mask_data;
      end
   end

   assign irq_req = |(edge_cap & irq_mask);
endmodule

// File: rtl/avalon_pio_bank.sv
// Avalon-MM PIO bank: NUM_OUT output and NUM_IN input channels with atomic set/clear,
// edge capture and a maskable level irq. Debounce enabled by AVALON_PIO_BANK_DEBOUNCE_EN.
module avalon_pio_bank
   import avalon_pio_bank_pkg::*;
#(
   parameter int          WIDTH           = 32,
   parameter int          NUM_OUT         = 4,
   parameter int          NUM_IN          = 2,
   parameter logic [31:0] OUT_RESET_VAL   = 32'h0,
   parameter int          EDGE_TYPE       = 0,
   parameter int          SYNC_STAGES     = 2,
   parameter int          DEBOUNCE_CYCLES = 1000,
   parameter int          CH_AW           = ch_addr_width(NUM_OUT, NUM_IN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CH_AW+2:0]         avs_address,
   input  logic                     avs_read,
   input  logic                     avs_write,
   input  logic [31:0]              avs_writedata,
   output logic [31:0]              avs_readdata,
   output logic                     irq,
   output logic [NUM_OUT*WIDTH-1:0] pio_out,
   input  logic [NUM_IN*WIDTH-1:0]  pio_in
);
   logic [2:0]       func;
   logic [CH_AW-1:0] ch;
   logic [WIDTH-1:0] wd;
   logic [31:0]      rd_next;

   logic [NUM_OUT-1:0][WIDTH-1:0] out_q;
   logic [NUM_IN-1:0][WIDTH-1:0]  in_filt, in_cap, in_mask;
   logic [NUM_IN-1:0]             in_irq, clr_wr, mask_wr;

   assign func    = avs_address[CH_AW+2:CH_AW];
   assign ch      = avs_address[CH_AW-1:0];
   assign wd      = avs_writedata[WIDTH-1:0];
   assign pio_out = out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT; i++) out_q[i] <= OUT_RESET_VAL[WIDTH-1:0];
      end else if (avs_write) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (ch == CH_AW'(i)) begin
               case (func)
                  FUNC_OUT_DATA: out_q[i] <= wd;
                  FUNC_OUT_SET:  out_q[i] <= out_q[i] | wd;
                  FUNC_OUT_CLR:  out_q[i] <= out_q[i] & ~wd;
                  default: ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      assign clr_wr[g]  = avs_write && (func == FUNC_EDGE_CAP) && (ch == CH_AW'(g));
      assign mask_wr[g] = avs_write && (func == FUNC_IRQ_MASK) && (ch == CH_AW'(g));

      pio_in_channel #(
         .WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE),
         .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk(clk), .reset(reset),
         .pio_in(pio_in[g*WIDTH +: WIDTH]),
         .clr_wr(clr_wr[g]), .clr_data(wd),
         .mask_wr(mask_wr[g]), .mask_data(wd),
         .filtered(in_filt[g]), .edge_cap(in_cap[g]),
         .irq_mask(in_mask[g]), .irq_req(in_irq[g])
      );
   end

   // Read mux sees only registered state, so a simultaneous write returns the pre-write value.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_OUT; i++)
         if (ch == CH_AW'(i) && func <= FUNC_OUT_CLR) rd_next[WIDTH-1:0] = out_q[i];
      for (int i = 0; i < NUM_IN; i++) begin
         if (ch == CH_AW'(i)) begin
            case (func)
               FUNC_IN_DATA:  rd_next[WIDTH-1:0] = in_filt[i];
               FUNC_EDGE_CAP: rd_next[WIDTH-1:0] = in_cap[i];
               FUNC_IRQ_MASK: rd_next[WIDTH-1:0] = in_mask[i];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avs_readdata <= '0;
         irq          <= 1'b0;
      end else begin
         avs_readdata <= avs_read ? rd_next : '0;
         irq          <= |in_irq;
      end
   end
endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed bench for avalon_pio_bank with a cycle-level behavioural model and literal checks.
module tb_avalon_pio_bank;
   import avalon_pio_bank_pkg::*;

   localparam int          WIDTH   = 32;
   localparam int          NUM_OUT = 4;
   localparam int          NUM_IN  = 2;
   localparam int          SS      = 2;
   localparam logic [31:0] RST_VAL = 32'h0000_00A5;
   localparam int          CH_AW   = ch_addr_width(NUM_OUT, NUM_IN);
`ifdef AVALON_PIO_BANK_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset;
   logic [CH_AW+2:0]         avs_address;
   logic                     avs_read, avs_write;
   logic [31:0]              avs_writedata, avs_readdata;
   logic                     irq;
   logic [NUM_OUT*WIDTH-1:0] pio_out;
   logic [NUM_IN*WIDTH-1:0]  pio_in;

   int total = 0;
   int bad   = 0;

   avalon_pio_bank #(
      .WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .OUT_RESET_VAL(RST_VAL),
      .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .irq(irq), .pio_out(pio_out), .pio_in(pio_in)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] m_out  [NUM_OUT];
   logic [31:0] m_cap  [NUM_IN];
   logic [31:0] m_mask [NUM_IN];
   logic [31:0] m_filt [NUM_IN];
   logic [31:0] m_prevf[NUM_IN];
   logic [31:0] m_hist [NUM_IN][SS];
   int          m_warm;
   logic        m_irq;
   logic [31:0] m_rd;
   bit          m_rd_chk = 1'b0;
   bit          started  = 1'b0;

   always @(posedge clk) begin
      logic [2:0]  f;
      int          c;
      logic        irq_n;
      logic [31:0] e, clr;
      f = avs_address[CH_AW+2:CH_AW];
      c = int'(avs_address[CH_AW-1:0]);
      if (reset) begin
         started = 1'b1;
         for (int i = 0; i < NUM_OUT; i++) m_out[i] = RST_VAL;
         for (int i = 0; i < NUM_IN; i++) begin
            m_cap[i] = 0; m_mask[i] = 0; m_filt[i] = 0; m_prevf[i] = 0;
            for (int s = 0; s < SS; s++) m_hist[i][s] = 0;
         end
         m_warm = 0; m_irq = 1'b0; m_rd = 0; m_rd_chk = 1'b1;
      end else begin
         m_rd_chk = avs_read && !(DEB && (f == 3'd3 || f == 3'd4));
         m_rd = 0;
         if (avs_read) begin
            if (f <= 3'd2 && c < NUM_OUT)      m_rd = m_out[c];
            else if (f == 3'd3 && c < NUM_IN)  m_rd = m_filt[c];
            else if (f == 3'd4 && c < NUM_IN)  m_rd = m_cap[c];
            else if (f == 3'd5 && c < NUM_IN)  m_rd = m_mask[c];
         end
         irq_n = 1'b0;
         for (int i = 0; i < NUM_IN; i++) irq_n |= |(m_cap[i] & m_mask[i]);
         for (int i = 0; i < NUM_IN; i++) begin
            e   = (m_warm >= SS + 1) ? (m_filt[i] & ~m_prevf[i]) : 32'h0;
            clr = (avs_write && f == 3'd4 && c == i) ? avs_writedata : 32'h0;
            m_cap[i] = (m_cap[i] & ~clr) | e;
            if (avs_write && f == 3'd5 && c == i) m_mask[i] = avs_writedata;
            m_prevf[i] = m_filt[i];
            for (int s = SS - 1; s > 0; s--) m_hist[i][s] = m_hist[i][s-1];
            m_hist[i][0] = pio_in[i*WIDTH +: WIDTH];
            m_filt[i] = m_hist[i][SS-1];
         end
         if (avs_write && c < NUM_OUT) begin
            if (f == 3'd0) m_out[c] = avs_writedata;
            if (f == 3'd1) m_out[c] = m_out[c] | avs_writedata;
            if (f == 3'd2) m_out[c] = m_out[c] & ~avs_writedata;
         end
         m_irq = irq_n;
         if (m_warm < 1000) m_warm++;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < NUM_OUT; i++) check("model pio_out", pio_out[i*WIDTH +: WIDTH], m_out[i]);
`ifndef AVALON_PIO_BANK_DEBOUNCE_EN
         check("model irq", {31'b0, irq}, {31'b0, m_irq});
`endif
         if (m_rd_chk) check("model readdata", avs_readdata, m_rd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic bus(input logic rd, input logic wr, input logic [2:0] f, input int c, input logic [31:0] d);
      avs_read = rd; avs_write = wr; avs_address = {f, CH_AW'(c)}; avs_writedata = d;
      @(posedge clk); #1;
      avs_read = 1'b0; avs_write = 1'b0;
   endtask

   task automatic wr(input logic [2:0] f, input int c, input logic [31:0] d);
      bus(1'b0, 1'b1, f, c, d);
   endtask

   task automatic rd(input string name, input logic [2:0] f, input int c, input logic [31:0] exp);
      bus(1'b1, 1'b0, f, c, 32'h0);
      check(name, avs_readdata, exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
      pio_in = '1;
      cyc(3);
      reset = 1'b0;
      // reset state
      rd("rst in_data",  FUNC_IN_DATA,  0, 32'h0);
      rd("rst edge_cap", FUNC_EDGE_CAP, 0, 32'h0);
      rd("rst irq_mask", FUNC_IRQ_MASK, 0, 32'h0);
      rd("rst out_data", FUNC_OUT_DATA, 0, RST_VAL);
      rd("rst out_set",  FUNC_OUT_SET,  0, RST_VAL);
      rd("rst out_clr",  FUNC_OUT_CLR,  0, RST_VAL);
      check("rst irq", {31'b0, irq}, 32'h0);
      cyc(20);
      rd("warm no edge ch0", FUNC_EDGE_CAP, 0, 32'h0);
      rd("warm no edge ch1", FUNC_EDGE_CAP, 1, 32'h0);
      rd("warm in_data", FUNC_IN_DATA, 0, 32'hFFFF_FFFF);
      check("warm irq", {31'b0, irq}, 32'h0);
      pio_in = '0;
      cyc(20);
      rd("falling ignored", FUNC_EDGE_CAP, 0, 32'h0);

      // outputs: data / set / clear
      wr(FUNC_OUT_DATA, 1, 32'h0000_00F0);
      check("out_data ch1", pio_out[63:32], 32'h0000_00F0);
      wr(FUNC_OUT_SET, 1, 32'h0000_000F);
      check("out_set ch1", pio_out[63:32], 32'h0000_00FF);
      wr(FUNC_OUT_CLR, 1, 32'h0000_0030);
      check("out_clr ch1", pio_out[63:32], 32'h0000_00CF);
      rd("rd out_data ch1", FUNC_OUT_DATA, 1, 32'h0000_00CF);
      rd("rd out_set ch1",  FUNC_OUT_SET,  1, 32'h0000_00CF);
      bus(1'b1, 1'b1, FUNC_OUT_DATA, 2, 32'h1234_5678);
      check("rw pre-write rd", avs_readdata, RST_VAL);
      check("rw ch2 out", pio_out[95:64], 32'h1234_5678);

`ifdef AVALON_PIO_BANK_DEBOUNCE_EN
      pio_in[31:0] = 32'h1;
      cyc(5);
      pio_in[31:0] = 32'h0;
      cyc(15);
      rd("glitch in_data", FUNC_IN_DATA, 0, 32'h0);
      rd("glitch no edge", FUNC_EDGE_CAP, 0, 32'h0);
      pio_in[31:0] = 32'h1;
      cyc(12);
      rd("pulse in_data", FUNC_IN_DATA, 0, 32'h1);
      pio_in[31:0] = 32'h0;
      cyc(5);
      rd("pulse edge", FUNC_EDGE_CAP, 0, 32'h1);
      wr(FUNC_EDGE_CAP, 0, 32'h1);
      cyc(20);
`else
      // rising edge capture timing and W1C
      pio_in[31:0] = 32'h5;
      cyc(2);
      rd("edge not yet", FUNC_EDGE_CAP, 0, 32'h0);
      rd("edge captured", FUNC_EDGE_CAP, 0, 32'h5);
      wr(FUNC_EDGE_CAP, 0, 32'h1);
      rd("w1c bit0", FUNC_EDGE_CAP, 0, 32'h4);
      // edge and W1C on the same bit in the same cycle
      pio_in[31:0] = 32'h4;
      cyc(4);
      pio_in[31:0] = 32'h5;
      cyc(2);
      wr(FUNC_EDGE_CAP, 0, 32'h1);
      rd("edge beats w1c", FUNC_EDGE_CAP, 0, 32'h5);
      // masked interrupt
      wr(FUNC_IRQ_MASK, 1, 32'h8);
      pio_in[35] = 1'b1;
      cyc(3);
      check("irq before", {31'b0, irq}, 32'h0);
      cyc(1);
      check("irq set", {31'b0, irq}, 32'h1);
      wr(FUNC_EDGE_CAP, 1, 32'h8);
      check("irq lag", {31'b0, irq}, 32'h1);
      cyc(1);
      check("irq clr", {31'b0, irq}, 32'h0);
      pio_in[34] = 1'b1;
      cyc(6);
      check("irq unmasked", {31'b0, irq}, 32'h0);
      rd("ch1 cap", FUNC_EDGE_CAP, 1, 32'h4);
`endif

      // out of range channels and reserved functions
      wr(FUNC_IRQ_MASK, 2, 32'hFF);
      rd("oor mask", FUNC_IRQ_MASK, 2, 32'h0);
      rd("oor in_data", FUNC_IN_DATA, 3, 32'h0);
      rd("oor cap", FUNC_EDGE_CAP, 3, 32'h0);
      wr(3'd6, 0, 32'hDEAD_BEEF);
      wr(3'd7, 1, 32'hDEAD_BEEF);
      rd("rsvd 6", 3'd6, 0, 32'h0);
      rd("rsvd 7", 3'd7, 1, 32'h0);
      rd("mask ch0", FUNC_IRQ_MASK, 0, 32'h0);

      // reset in the middle of a read
      avs_read = 1'b1; avs_address = {FUNC_OUT_DATA, CH_AW'(1)}; reset = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0; reset = 1'b0;
      check("midrst readdata", avs_readdata, 32'h0);
      check("midrst out ch1", pio_out[63:32], RST_VAL);
      pio_in[31:0] = 32'h5;
      cyc(20);
      rd("midrst cap", FUNC_EDGE_CAP, 0, 32'h0);
      rd("midrst in", FUNC_IN_DATA, 0, 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
